// File: rtl/mips_decode_alu_stage_if.sv
// Bundle between the ID/EX stage logic and the decode/ALU slice.
// The master drives the instruction fields and operands; the slave returns the EX/MEM values.
interface mips_decode_alu_stage_if;
    logic        bubble;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b_reg;
    logic [31:0] seimm;
    logic [31:0] result;
    logic        zero;
    logic [31:0] store_data;
    logic        regdst;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        branch_eq;
    logic        branch_ne;
    logic        jump;
    logic [3:0]  aluctl;

    modport master (
        output bubble, opcode, funct, a, b_reg, seimm,
        input  result, zero, store_data, regdst, regwrite, memread, memwrite,
               memtoreg, branch_eq, branch_ne, jump, aluctl
    );

    modport slave (
        input  bubble, opcode, funct, a, b_reg, seimm,
        output result, zero, store_data, regdst, regwrite, memread, memwrite,
               memtoreg, branch_eq, branch_ne, jump, aluctl
    );
endinterface

// File: rtl/mips_decode_alu_stage.sv
// Decodes the primary opcode and funct, executes the 32-bit ALU operation,
// and registers the result, zero flag and control signals into EX/MEM.
module mips_decode_alu_stage (
    input  logic                        clk,
    input  logic                        rst_n,
    mips_decode_alu_stage_if.slave      bus
);
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    logic [1:0]  aluop_s;
    logic        alusrc_s;
    logic [7:0]  ctl_s;     // {regdst, regwrite, memread, memwrite, memtoreg, branch_eq, branch_ne, jump}
    logic [3:0]  aluctl_s;
    logic [31:0] opb_s;
    logic [31:0] alu_s;

    logic [31:0] result_r;
    logic        zero_r;
    logic [31:0] store_data_r;
    logic [7:0]  ctl_r;

    // Primary-opcode decode into ALU-op, operand-B select and control bits.
    always_comb begin
        aluop_s  = 2'b00;
        alusrc_s = 1'b0;
        ctl_s    = 8'b0000_0000;
        case (bus.opcode)
            6'b000000: begin aluop_s = 2'b10; ctl_s = 8'b1100_0000; end
            6'b100011: begin alusrc_s = 1'b1; ctl_s = 8'b0110_1000; end
            6'b101011: begin alusrc_s = 1'b1; ctl_s = 8'b0001_0000; end
            6'b001000: begin alusrc_s = 1'b1; ctl_s = 8'b0100_0000; end
            6'b000100: begin aluop_s = 2'b01; ctl_s = 8'b0000_0100; end
            6'b000101: begin aluop_s = 2'b01; ctl_s = 8'b0000_0010; end
            6'b000010: begin ctl_s = 8'b0000_0001; end
            default:   begin aluop_s = 2'b00; ctl_s = 8'b0000_0000; end
        endcase
    end

    // ALU operation from ALU-op, with funct consulted only for R-type.
    always_comb begin
        aluctl_s = ALU_AND;
        case (aluop_s)
            2'b00: aluctl_s = ALU_ADD;
            2'b01: aluctl_s = ALU_SUB;
            2'b10: begin
                case (bus.funct)
                    6'b100000: aluctl_s = ALU_ADD;
                    6'b100010: aluctl_s = ALU_SUB;
                    6'b100100: aluctl_s = ALU_AND;
                    6'b100101: aluctl_s = ALU_OR;
                    6'b100110: aluctl_s = ALU_XOR;
                    6'b100111: aluctl_s = ALU_NOR;
                    6'b101010: aluctl_s = ALU_SLT;
                    default:   aluctl_s = ALU_AND;
                endcase
            end
            default: aluctl_s = ALU_AND;
        endcase
    end

    assign opb_s = alusrc_s ? bus.seimm : bus.b_reg;

    // 32-bit ALU; add/sub wrap silently and unknown codes yield zero.
    always_comb begin
        alu_s = 32'h0000_0000;
        case (aluctl_s)
            ALU_AND: alu_s = bus.a & opb_s;
            ALU_OR:  alu_s = bus.a | opb_s;
            ALU_XOR: alu_s = bus.a ^ opb_s;
            ALU_NOR: alu_s = ~(bus.a | opb_s);
            ALU_ADD: alu_s = bus.a + opb_s;
            ALU_SUB: alu_s = bus.a - opb_s;
            ALU_SLT: alu_s = ($signed(bus.a) < $signed(opb_s)) ? 32'd1 : 32'd0;
            default: alu_s = 32'h0000_0000;
        endcase
    end

    // EX/MEM register; a bubble clears only the control bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r     <= 32'h0000_0000;
            zero_r       <= 1'b0;
            store_data_r <= 32'h0000_0000;
            ctl_r        <= 8'b0000_0000;
        end else begin
            result_r     <= alu_s;
            zero_r       <= (alu_s == 32'h0000_0000);
            store_data_r <= bus.b_reg;
            ctl_r        <= bus.bubble ? 8'b0000_0000 : ctl_s;
        end
    end

    assign bus.result     = result_r;
    assign bus.zero       = zero_r;
    assign bus.store_data = store_data_r;
    assign bus.regdst     = ctl_r[7];
    assign bus.regwrite   = ctl_r[6];
    assign bus.memread    = ctl_r[5];
    assign bus.memwrite   = ctl_r[4];
    assign bus.memtoreg   = ctl_r[3];
    assign bus.branch_eq  = ctl_r[2];
    assign bus.branch_ne  = ctl_r[1];
    assign bus.jump       = ctl_r[0];
    assign bus.aluctl     = aluctl_s;
endmodule

// File: tb/tb_mips_decode_alu_stage.sv
// Directed-vector bench: the driver queues hand-computed expectations,
// and an independent monitor compares each registered output after the capturing edge.
module tb_mips_decode_alu_stage;
    logic clk;
    logic rst_n;
    mips_decode_alu_stage_if bus ();

    mips_decode_alu_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        string       name;
        logic [31:0] result;
        logic        zero;
        logic [31:0] sd;
        logic [7:0]  ctl;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ctl_now();
        return {bus.regdst, bus.regwrite, bus.memread, bus.memwrite,
                bus.memtoreg, bus.branch_eq, bus.branch_ne, bus.jump};
    endfunction

    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: compare the registered outputs one delta after each capturing edge.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "result",     bus.result,            e.result);
            chk(e.name, "zero",       {31'd0, bus.zero},     {31'd0, e.zero});
            chk(e.name, "store_data", bus.store_data,        e.sd);
            chk(e.name, "ctl",        {24'd0, ctl_now()},    {24'd0, e.ctl});
        end
    end

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic bub);
        bus.opcode = op;
        bus.funct  = fn;
        bus.a      = a;
        bus.b_reg  = b;
        bus.seimm  = imm;
        bus.bubble = bub;
    endtask

    task automatic apply(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic bub,
                         input logic [31:0] er, input logic ez, input logic [7:0] ectl,
                         input logic [3:0] ealu);
        exp_t e;
        @(negedge clk);
        drive(op, fn, a, b, imm, bub);
        #1;
        chk(name, "aluctl", {28'd0, bus.aluctl}, {28'd0, ealu});
        e.name = name; e.result = er; e.zero = ez; e.sd = b; e.ctl = ectl;
        q.push_back(e);
    endtask

    task automatic check_all_zero(input string name);
        chk(name, "result",     bus.result,         32'h0000_0000);
        chk(name, "store_data", bus.store_data,     32'h0000_0000);
        chk(name, "zero_ctl",   {23'd0, bus.zero, ctl_now()}, 32'h0000_0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(6'b100011, 6'b000000, 32'h0000_0100, 32'h0000_BEEF, 32'hFFFF_FFFC, 1'b0);
        repeat (2) @(negedge clk);
        check_all_zero("reset_hold");
        rst_n = 1'b1;
        // First edge after release loads the lw already on the inputs.
        begin
            exp_t e;
            e.name = "reset_release_lw"; e.result = 32'h0000_00FC; e.zero = 1'b0;
            e.sd = 32'h0000_BEEF; e.ctl = 8'b0110_1000;
            q.push_back(e);
        end

        apply("r_add",  6'b000000, 6'b100000, 32'h0000_000F, 32'h0000_00F0, 32'h0, 1'b0, 32'h0000_00FF, 1'b0, 8'b1100_0000, 4'b0010);
        apply("r_and",  6'b000000, 6'b100100, 32'h0000_000F, 32'h0000_00F0, 32'h0, 1'b0, 32'h0000_0000, 1'b1, 8'b1100_0000, 4'b0000);
        apply("r_or",   6'b000000, 6'b100101, 32'h0000_000F, 32'h0000_00F0, 32'h0, 1'b0, 32'h0000_00FF, 1'b0, 8'b1100_0000, 4'b0001);
        apply("r_xor",  6'b000000, 6'b100110, 32'h0000_000F, 32'h0000_00F0, 32'h0, 1'b0, 32'h0000_00FF, 1'b0, 8'b1100_0000, 4'b1101);
        apply("r_nor",  6'b000000, 6'b100111, 32'h0000_000F, 32'h0000_00F0, 32'h0, 1'b0, 32'hFFFF_FF00, 1'b0, 8'b1100_0000, 4'b1100);
        apply("r_sub",  6'b000000, 6'b100010, 32'h0000_000F, 32'h0000_00F0, 32'h0, 1'b0, 32'hFFFF_FF1F, 1'b0, 8'b1100_0000, 4'b0110);
        apply("r_badfn",6'b000000, 6'b000000, 32'h0000_000F, 32'h0000_00F0, 32'h0, 1'b0, 32'h0000_0000, 1'b1, 8'b1100_0000, 4'b0000);
        apply("slt_lt", 6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 32'h0000_0001, 1'b0, 8'b1100_0000, 4'b0111);
        apply("slt_ge", 6'b000000, 6'b101010, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0000_0000, 1'b1, 8'b1100_0000, 4'b0111);
        apply("add_ovf",6'b000000, 6'b100000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 32'h8000_0000, 1'b0, 8'b1100_0000, 4'b0010);
        apply("lw",     6'b100011, 6'b100100, 32'h0000_0100, 32'h0000_DEAD, 32'hFFFF_FFFC, 1'b0, 32'h0000_00FC, 1'b0, 8'b0110_1000, 4'b0010);
        apply("sw",     6'b101011, 6'b000000, 32'h0000_0100, 32'hCAFE_BABE, 32'h0000_0008, 1'b0, 32'h0000_0108, 1'b0, 8'b0001_0000, 4'b0010);
        apply("addi",   6'b001000, 6'b000000, 32'h0000_0005, 32'h0000_0077, 32'hFFFF_FFFB, 1'b0, 32'h0000_0000, 1'b1, 8'b0100_0000, 4'b0010);
        apply("beq",    6'b000100, 6'b100101, 32'h0000_1234, 32'h0000_1234, 32'h0000_0040, 1'b0, 32'h0000_0000, 1'b1, 8'b0000_0100, 4'b0110);
        apply("bne_eq", 6'b000101, 6'b000000, 32'h0000_1234, 32'h0000_1234, 32'h0000_0040, 1'b0, 32'h0000_0000, 1'b1, 8'b0000_0010, 4'b0110);
        apply("bne_ne", 6'b000101, 6'b000000, 32'h0000_1234, 32'h0000_1235, 32'h0000_0040, 1'b0, 32'hFFFF_FFFF, 1'b0, 8'b0000_0010, 4'b0110);
        apply("lw_bub", 6'b100011, 6'b000000, 32'h0000_0100, 32'h0000_0011, 32'hFFFF_FFFC, 1'b1, 32'h0000_00FC, 1'b0, 8'b0000_0000, 4'b0010);
        apply("illegal",6'b111111, 6'b100010, 32'h0000_0003, 32'h0000_0004, 32'h0000_0100, 1'b0, 32'h0000_0007, 1'b0, 8'b0000_0000, 4'b0010);
        apply("jump",   6'b000010, 6'b000000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0100, 1'b0, 32'h0000_0003, 1'b0, 8'b0000_0001, 4'b0010);

        // Mid-stream reset pulse between edges, with a bubble also asserted.
        @(negedge clk);
        drive(6'b000000, 6'b100101, 32'h0000_0F00, 32'h0000_000F, 32'h0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_async");
        #1;
        rst_n = 1'b1;
        bus.bubble = 1'b0;
        begin
            exp_t e;
            e.name = "post_reset_or"; e.result = 32'h0000_0F0F; e.zero = 1'b0;
            e.sd = 32'h0000_000F; e.ctl = 8'b1100_0000;
            q.push_back(e);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
